// File: rtl/mem_arb_pkg.sv
// Shared types, funct3 size codes and the alignment helper for the memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Low two funct3 bits give the size; bit 2 only selects zero/sign extension.
  function automatic logic misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
    logic mis;
    mis = 1'b0;
    case (funct3[1:0])
      2'b01:   mis = addr_lo[0];
      2'b10:   mis = |addr_lo;
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester, response and memory-side signals of the shared memory port.
interface mem_port_arbiter_if #(
  parameter int unsigned NUM_PORTS = 2,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32
);
  logic [NUM_PORTS-1:0]        req_valid;
  logic [NUM_PORTS-1:0]        req_ready;
  logic [NUM_PORTS-1:0]        req_we;
  logic [NUM_PORTS*3-1:0]      req_funct3;
  logic [NUM_PORTS*ADDR_W-1:0] req_addr;
  logic [NUM_PORTS*DATA_W-1:0] req_wdata;
  logic [NUM_PORTS-1:0]        rsp_valid;
  logic [DATA_W-1:0]           rsp_rdata;
  logic                        rsp_err;
  logic                        mem_we;
  logic [2:0]                  mem_funct3;
  logic [ADDR_W-1:0]           mem_addr;
  logic [DATA_W-1:0]           mem_wdata;
  logic [DATA_W-1:0]           mem_rdata;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
           mem_we, mem_funct3, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
           mem_we, mem_funct3, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter_rr.sv
// Combinational round-robin picker: first requester after i_last, wrapping N-1 -> 0.
module rr_arbiter #(
  parameter int unsigned N     = 2,
  parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_last,
  output logic [N-1:0]     o_grant_c,
  output logic [IDX_W-1:0] o_idx_c
);

  // Walk from the farthest candidate to the nearest so the nearest match wins.
  always_comb begin
    logic [IDX_W-1:0] pos;
    o_grant_c = '0;
    o_idx_c   = '0;
    pos       = '0;
    for (int k = int'(N); k >= 1; k--) begin
      pos = IDX_W'((int'(i_last) + k) % int'(N));
      if (i_req[pos]) begin
        o_grant_c      = '0;
        o_grant_c[pos] = 1'b1;
        o_idx_c        = pos;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin sharing of one memory port between NUM_PORTS requesters, one access at a time.
// Optional MEM_ARB_ALIGN_CHECK_EN: misaligned half/word accesses are flagged and never reach memory.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned NUM_PORTS = 2,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MEM_LAT   = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_port_arbiter_if.slave bus
);

  localparam int unsigned IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int unsigned CNT_W = (MEM_LAT > 0) ? $clog2(MEM_LAT + 1) : 1;

  state_t               r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [IDX_W-1:0]     r_last;
  logic [NUM_PORTS-1:0] r_owner;
  logic                 r_we;
  logic                 r_err;
  logic [2:0]           r_funct3;
  logic [ADDR_W-1:0]    r_addr;
  logic [DATA_W-1:0]    r_wdata;
  logic                 r_mem_we;
  logic [NUM_PORTS-1:0] r_rsp_valid;
  logic [DATA_W-1:0]    r_rsp_rdata;
  logic                 r_rsp_err;

  logic [NUM_PORTS-1:0] w_grant;
  logic [IDX_W-1:0]     w_idx;
  logic                 w_sel_we;
  logic [2:0]           w_sel_f3;
  logic [ADDR_W-1:0]    w_sel_addr;
  logic [DATA_W-1:0]    w_sel_wdata;
  logic                 w_mis;
  logic                 w_accept;

  rr_arbiter #(
    .N     (NUM_PORTS),
    .IDX_W (IDX_W)
  ) u_rr (
    .i_req     (bus.req_valid),
    .i_last    (r_last),
    .o_grant_c (w_grant),
    .o_idx_c   (w_idx)
  );

  // Route the granted port's request fields.
  always_comb begin
    w_sel_we    = 1'b0;
    w_sel_f3    = '0;
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    for (int p = 0; p < int'(NUM_PORTS); p++) begin
      if (w_grant[p]) begin
        w_sel_we    = bus.req_we[p];
        w_sel_f3    = bus.req_funct3[3*p +: 3];
        w_sel_addr  = bus.req_addr[ADDR_W*p +: ADDR_W];
        w_sel_wdata = bus.req_wdata[DATA_W*p +: DATA_W];
      end
    end
  end

`ifdef MEM_ARB_ALIGN_CHECK_EN
  assign w_mis = misaligned(w_sel_f3, w_sel_addr[1:0]);
`else
  assign w_mis = 1'b0;
`endif

  assign w_accept      = (r_state == IDLE) && (|w_grant);
  assign bus.req_ready = (rst_n && r_state == IDLE) ? w_grant : '0;

  assign bus.mem_we     = r_mem_we;
  assign bus.mem_funct3 = r_funct3;
  assign bus.mem_addr   = r_addr;
  assign bus.mem_wdata  = r_wdata;
  assign bus.rsp_valid  = r_rsp_valid;
  assign bus.rsp_rdata  = r_rsp_rdata;
  assign bus.rsp_err    = r_rsp_err;

  // Access sequencer: accept in IDLE, hold the memory signals through BUSY, pulse the response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_last      <= IDX_W'(NUM_PORTS - 1);
      r_owner     <= '0;
      r_we        <= 1'b0;
      r_err       <= 1'b0;
      r_funct3    <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_mem_we    <= 1'b0;
      r_rsp_valid <= '0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_owner  <= w_grant;
            r_last   <= w_idx;
            r_we     <= w_sel_we;
            r_err    <= w_mis;
            r_funct3 <= w_sel_f3;
            r_addr   <= w_sel_addr;
            r_wdata  <= w_sel_wdata;
            r_cnt    <= '0;
            r_mem_we <= w_sel_we & ~w_mis;
            r_state  <= BUSY;
          end
        end
        BUSY: begin
          r_mem_we <= 1'b0;
          if (r_cnt == CNT_W'(MEM_LAT)) begin
            r_rsp_valid <= r_owner;
            r_rsp_rdata <= (r_we || r_err) ? '0 : bus.mem_rdata;
            r_rsp_err   <= r_err;
            r_state     <= RESP;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        RESP: begin
          r_rsp_valid <= '0;
          r_rsp_rdata <= '0;
          r_rsp_err   <= 1'b0;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (MEM_LAT 0 and 2), a transaction-timeline model per instance.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int unsigned NP = 2;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  logic [1:0][NP-1:0]    s_valid;
  logic [1:0][NP-1:0]    s_we;
  logic [1:0][3*NP-1:0]  s_f3;
  logic [1:0][AW*NP-1:0] s_addr;
  logic [1:0][DW*NP-1:0] s_wdata;

  logic [1:0][NP-1:0] o_ready;
  logic [1:0][NP-1:0] o_rsp;
  logic [1:0]         o_mem_we;
  logic [1:0][AW-1:0] o_mem_addr;
  logic [1:0][DW-1:0] o_rdata;
  logic [1:0]         o_err;

  task automatic chk(input int d, input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d @cyc %0d: got 0x%0h expected 0x%0h", nm, d, cyc, act, exp);
    end
  endtask

  for (genvar d = 0; d < 2; d++) begin : g_dut
    localparam int LAT = (d == 0) ? 0 : 2;

    mem_port_arbiter_if #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_port_arbiter #(
      .NUM_PORTS (NP),
      .ADDR_W    (AW),
      .DATA_W    (DW),
      .MEM_LAT   (LAT)
    ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
    );

    assign bus.req_valid  = s_valid[d];
    assign bus.req_we     = s_we[d];
    assign bus.req_funct3 = s_f3[d];
    assign bus.req_addr   = s_addr[d];
    assign bus.req_wdata  = s_wdata[d];

    assign o_ready[d]    = bus.req_ready;
    assign o_rsp[d]      = bus.rsp_valid;
    assign o_mem_we[d]   = bus.mem_we;
    assign o_mem_addr[d] = bus.mem_addr;
    assign o_rdata[d]    = bus.rsp_rdata;
    assign o_err[d]      = bus.rsp_err;

    // Word-addressed memory seen by the DUT, and the model's own copy of it.
    logic [DW-1:0] mem    [64];
    logic [DW-1:0] shadow [64];

    initial begin
      for (int i = 0; i < 64; i++) begin
        mem[i]    = '0;
        shadow[i] = '0;
      end
      mem[4]    = 32'hDEADBEEF;
      shadow[4] = 32'hDEADBEEF;
      mem[8]    = 32'hCAFEF00D;
      shadow[8] = 32'hCAFEF00D;
    end

    always_comb bus.mem_rdata = mem[bus.mem_addr[7:2]];

    always @(posedge clk) begin
      if (bus.mem_we) mem[bus.mem_addr[7:2]] = bus.mem_wdata;
    end

    // Model state: age counts cycles since accept (0 = free to accept).
    int            age  = 0;
    int            last = int'(NP) - 1;
    logic [NP-1:0] own;
    logic          m_we, m_err;
    logic [2:0]    m_f3;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, m_rdata;

    always @(negedge clk) begin : model
      logic [NP-1:0] e_ready, e_rsp;
      logic          e_we, e_err;
      logic [DW-1:0] e_rdata;
      int            gp;
      e_ready = '0;
      e_rsp   = '0;
      e_we    = 1'b0;
      e_err   = 1'b0;
      e_rdata = '0;
      gp      = -1;
      if (!rst_n) begin
        age  = 0;
        last = int'(NP) - 1;
        chk(d, "rst_mem_addr", 64'(bus.mem_addr), 64'd0);
        chk(d, "rst_mem_f3", 64'(bus.mem_funct3), 64'd0);
        chk(d, "rst_mem_wdata", 64'(bus.mem_wdata), 64'd0);
      end else if (age == 0) begin
        for (int k = 1; k <= int'(NP); k++) begin
          if (gp < 0 && s_valid[d][(last + k) % int'(NP)]) gp = (last + k) % int'(NP);
        end
        if (gp >= 0) e_ready[gp] = 1'b1;
      end else if (age <= LAT + 1) begin
        e_we = (age == 1) && m_we && !m_err;
        chk(d, "busy_mem_addr", 64'(bus.mem_addr), 64'(m_addr));
        chk(d, "busy_mem_f3", 64'(bus.mem_funct3), 64'(m_f3));
        chk(d, "busy_mem_wdata", 64'(bus.mem_wdata), 64'(m_wdata));
        if (age == LAT + 1) m_rdata = (m_we || m_err) ? '0 : shadow[m_addr[7:2]];
      end else begin
        e_rsp   = own;
        e_rdata = m_rdata;
        e_err   = m_err;
      end
      chk(d, "req_ready", 64'(bus.req_ready), 64'(e_ready));
      chk(d, "mem_we", 64'(bus.mem_we), 64'(e_we));
      chk(d, "rsp_valid", 64'(bus.rsp_valid), 64'(e_rsp));
      chk(d, "rsp_rdata", 64'(bus.rsp_rdata), 64'(e_rdata));
      chk(d, "rsp_err", 64'(bus.rsp_err), 64'(e_err));
      if (rst_n) begin
        if (e_we) shadow[m_addr[7:2]] = m_wdata;
        if (age == 0) begin
          if (gp >= 0) begin
            own     = e_ready;
            last    = gp;
            m_we    = s_we[d][gp];
            m_f3    = s_f3[d][3*gp +: 3];
            m_addr  = s_addr[d][AW*gp +: AW];
            m_wdata = s_wdata[d][DW*gp +: DW];
`ifdef MEM_ARB_ALIGN_CHECK_EN
            m_err = ((m_f3 == F3_H || m_f3 == F3_HU) && m_addr[0]) ||
                    (m_f3 == F3_W && m_addr[1:0] != 2'b00);
`else
            m_err = 1'b0;
`endif
            age = 1;
          end
        end else if (age == LAT + 2) begin
          age = 0;
        end else begin
          age = age + 1;
        end
      end
    end
  end

  task automatic wait_grant(input int d, input int p, output int t);
    t = -1;
    for (int w = 0; w < 20 && t < 0; w++) begin
      @(negedge clk);
      if (o_ready[d][p]) t = cyc;
    end
    if (t < 0) chk(d, "grant_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1 s_valid[d][p] = 1'b0;
  endtask

  task automatic issue(input int d, input int p, input logic we, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd, output int t);
    @(posedge clk);
    #1;
    s_we[d][p]             = we;
    s_f3[d][3*p +: 3]      = f3;
    s_addr[d][AW*p +: AW]  = a;
    s_wdata[d][DW*p +: DW] = wd;
    s_valid[d][p]          = 1'b1;
    wait_grant(d, p, t);
  endtask

  task automatic collect(input int d, input int p, output int t, output logic [31:0] rd,
                         output logic er, output int nwe);
    t   = -1;
    nwe = 0;
    rd  = '0;
    er  = 1'b0;
    for (int w = 0; w < 20 && t < 0; w++) begin
      @(negedge clk);
      if (o_mem_we[d]) nwe++;
      if (o_rsp[d][p]) begin
        t  = cyc;
        rd = o_rdata[d];
        er = o_err[d];
      end
    end
    if (t < 0) chk(d, "rsp_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    int          t, t0, tr, nwe;
    int          gidx [4];
    int          gcyc [4];
    logic [31:0] rd;
    logic        er;

    s_valid = '0;
    s_we    = '0;
    s_f3    = '0;
    s_addr  = '0;
    s_wdata = '0;
    rst_n   = 1'b0;

    // Both ports requesting loads straight out of reset.
    s_f3[0]    = {F3_W, F3_W};
    s_addr[0]  = {32'h20, 32'h10};
    s_valid[0] = 2'b11;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk(0, "rst_ready_forced", 64'(o_ready[0]), 64'd0);
    chk(0, "rst_rsp_valid", 64'(o_rsp[0]), 64'd0);
    chk(0, "rst_mem_we", 64'(o_mem_we[0]), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      gidx[i] = -1;
      gcyc[i] = 0;
      for (int w = 0; w < 10 && gidx[i] < 0; w++) begin
        @(negedge clk);
        if (o_ready[0] != '0) begin
          gidx[i] = o_ready[0][1] ? 1 : 0;
          gcyc[i] = cyc;
        end
      end
    end
    @(posedge clk);
    #1 s_valid[0] = '0;
    chk(0, "rr_grant0", 64'(gidx[0]), 64'd0);
    chk(0, "rr_grant1", 64'(gidx[1]), 64'd1);
    chk(0, "rr_grant2", 64'(gidx[2]), 64'd0);
    chk(0, "rr_grant3", 64'(gidx[3]), 64'd1);
    for (int i = 1; i < 4; i++) chk(0, "rr_spacing", 64'(gcyc[i] - gcyc[i-1]), 64'd3);
    repeat (4) @(posedge clk);

    // Single load, zero extra latency.
    issue(0, 0, 1'b0, F3_W, 32'h10, 32'h0, t);
    collect(0, 0, t0, rd, er, nwe);
    chk(0, "t1_latency", 64'(t0 - t), 64'd2);
    chk(0, "t1_rdata", 64'(rd), 64'hDEADBEEF);

    // Store from port 1, then read it back through port 0.
    issue(0, 1, 1'b1, F3_W, 32'h8, 32'h12345678, t);
    collect(0, 1, t0, rd, er, nwe);
    chk(0, "t3_we_cycles", 64'(nwe), 64'd1);
    chk(0, "t3_store_rdata", 64'(rd), 64'd0);
    chk(0, "t3_store_lat", 64'(t0 - t), 64'd2);
    issue(0, 0, 1'b0, F3_W, 32'h8, 32'h0, t);
    collect(0, 0, t0, rd, er, nwe);
    chk(0, "t3_readback", 64'(rd), 64'h12345678);

    // Two extra memory latency cycles.
    issue(1, 0, 1'b0, F3_W, 32'h10, 32'h0, t);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      chk(1, "t4_addr_stable", 64'(o_mem_addr[1]), 64'h10);
    end
    collect(1, 0, t0, rd, er, nwe);
    chk(1, "t4_latency", 64'(t0 - t), 64'd4);
    chk(1, "t4_rdata", 64'(rd), 64'hDEADBEEF);

    // Reset while a store is in its write cycle.
    issue(0, 0, 1'b1, F3_W, 32'h30, 32'hAAAA5555, t);
    #1 chk(0, "t5_we_before_reset", 64'(o_mem_we[0]), 64'd1);
    rst_n = 1'b0;
    #1 chk(0, "t5_we_at_reset", 64'(o_mem_we[0]), 64'd0);
    s_we[0]    = 2'b00;
    s_f3[0]    = {F3_W, F3_W};
    s_addr[0]  = {32'h20, 32'h30};
    s_valid[0] = 2'b11;
    @(negedge clk);
    chk(0, "t5_no_rsp_in_reset", 64'(o_rsp[0]), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tr = cyc;
    wait_grant(0, 0, t);
    chk(0, "t5_first_grant_port0", 64'(t), 64'(tr));
    collect(0, 0, t0, rd, er, nwe);
    chk(0, "t5_abandoned_store", 64'(rd), 64'd0);
    wait_grant(0, 1, t);
    collect(0, 1, t0, rd, er, nwe);
    chk(0, "t5_port1_rdata", 64'(rd), 64'hCAFEF00D);

    // Misaligned word store.
    issue(0, 1, 1'b1, F3_W, 32'h6, 32'h55AA55AA, t);
    collect(0, 1, t0, rd, er, nwe);
    chk(0, "t6_latency", 64'(t0 - t), 64'd2);
    chk(0, "t6_rdata", 64'(rd), 64'd0);
`ifdef MEM_ARB_ALIGN_CHECK_EN
    chk(0, "t6_we_cycles", 64'(nwe), 64'd0);
    chk(0, "t6_err", 64'(er), 64'd1);
`else
    chk(0, "t6_we_cycles", 64'(nwe), 64'd1);
    chk(0, "t6_err", 64'(er), 64'd0);
`endif
    issue(0, 0, 1'b0, F3_W, 32'h4, 32'h0, t);
    collect(0, 0, t0, rd, er, nwe);
`ifdef MEM_ARB_ALIGN_CHECK_EN
    chk(0, "t6_readback", 64'(rd), 64'd0);
`else
    chk(0, "t6_readback", 64'(rd), 64'h55AA55AA);
`endif

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
